pomodoro_sequencer: RTL and testbench
=====================================

Name: pomodoro_sequencer

Overview:
- Parametrised successor of the single-shot countdown timer.
- Runs an automatic work / short-break / long-break cycle, with start/pause, skip and clear controls and a BCD completed-session counter.
- Outputs a BCD mm:ss down-count and status that the board top packs into the 8-digit 74HC595 display data word.
- Counts in BCD directly, so no divide/modulo chains are needed.

Parameters:
- CLK_HZ, 125000000, input clock frequency; the prescaler terminal count is CLK_HZ-1.
- WORK_SEC, 1500, work phase length in seconds; legal range 1..5999.
- SHORT_SEC, 300, short break length in seconds; legal range 1..5999.
- LONG_SEC, 900, long break length in seconds; legal range 1..5999.
- LONG_EVERY, 4, number of completed work phases before a long break; legal range 1..15.
- AUTO_START, 0, behaviour after a phase ends: 1 = the next phase runs immediately, 0 = the next phase loads and waits in IDLE.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start_pause  in  1  single-cycle pulse (edge-detected upstream); toggles run/pause.
- skip  in  1  single-cycle pulse; abandon the current phase and load the next one.
- clr  in  1  single-cycle pulse; return to the WORK phase, full time, sessions=0.
- mm_bcd  out  8  minutes, two BCD digits {tens, ones}.
- ss_bcd  out  8  seconds, two BCD digits {tens (0-5), ones}.
- phase  out  2  current phase: 0=WORK, 1=SHORT, 2=LONG.
- running  out  1  high while in the RUN state.
- sess_bcd  out  16  completed work sessions, four BCD digits.
- done  out  1  one-cycle pulse when a phase reaches 00:00.

Behaviour:
- Reset (asynchronous, all registers):
  - phase=WORK; mm:ss = WORK_SEC as BCD.
  - running=0, done=0, sess_bcd=0, prescaler=0.
  - Work-in-cycle counter wcnt=0; state=IDLE.
- States:
  - IDLE: time loaded, not counting.
    - start_pause -> RUN.
  - RUN: counting down.
    - start_pause -> PAUSE.
    - Terminal second -> phase end.
  - PAUSE: not counting; the prescaler value is held.
    - start_pause -> RUN; the count resumes mid-second.
- Prescaler:
  - Increments only in RUN.
  - When it equals CLK_HZ-1, it wraps to 0 and emits an internal tick in that cycle.
- Tick handling (in RUN):
  - Decrement mm:ss in BCD with borrow: ss ones 0 -> 9 with borrow; ss tens 0 -> 5 with borrow; same scheme for mm.
  - If mm:ss==00:01 at the tick, the display becomes 00:00 and a phase end occurs in the same cycle.
- Phase end (in the cycle the display reaches 00:00):
  - done=1 for exactly one cycle; prescaler cleared.
  - If phase==WORK: sess_bcd increments in BCD and wraps 9999 -> 0000. Then:
    - if wcnt==LONG_EVERY-1: next phase=LONG, wcnt=0;
    - otherwise: next phase=SHORT, wcnt+1.
  - If phase is SHORT or LONG: next phase=WORK.
  - Next cycle: mm:ss holds the next phase's full time; state=RUN if AUTO_START=1, else IDLE.
  - 00:00 is therefore never held for more than one cycle.
- Skip:
  - Same next-phase selection as a phase end, but sess_bcd and wcnt are NOT advanced and done is not asserted.
  - A skip from WORK always goes to SHORT.
  - Prescaler cleared; state becomes IDLE regardless of AUTO_START.
- Clr: identical to reset, but synchronous.
- Priority in one cycle: clr > skip > phase end > start_pause.
  - A start_pause arriving in the phase-end cycle is ignored.
  - A skip arriving in the phase-end cycle wins: done is not pulsed and sess_bcd is unchanged.
- Output timing: all outputs are registered; latency from an input pulse to the output change is 1 cycle.
- Unused phase encoding 3 is never produced.

Decomposition:
- Package pomodoro_pkg:
  - phase encodings (WORK/SHORT/LONG);
  - state encodings (IDLE/RUN/PAUSE);
  - constant function sec_to_bcd(sec) returning a 16-bit {mm,ss} BCD value, used at elaboration for the three load values.
- Sub-module bcd_down_counter, 4 digits with radixes 10/6/10/10:
  - inputs: load value, load strobe, dec strobe;
  - outputs: BCD value and a zero-next flag.
- The session BCD increment stays inline in the top module.

Test Plan (simulate with CLK_HZ=4, WORK_SEC=3, SHORT_SEC=2, LONG_SEC=5, LONG_EVERY=2):
- Reset then idle 20 cycles -> mm:ss=00:03, phase=0, running=0, no done.
- start_pause, run 12 cycles:
  - display shows 00:02, 00:01, 00:00;
  - one-cycle done at cycle 12; sess=0001;
  - phase=1 with 00:02 loaded; running=0 (AUTO_START=0).
- Pause and resume:
  - start_pause, then start_pause again at prescaler=2; 10 cycles later start_pause again;
  - the next tick arrives 2 cycles after resume and the display resumes from its held value.
- Complete two WORK phases, each followed by its break:
  - after the second WORK, phase=2 with 00:05 loaded; sess=0002.
- skip during WORK -> phase=1, sess unchanged, done never asserted, running=0.
- Boundary cases:
  - preload sess to 9999, complete WORK -> sess=0000;
  - pulse clr and skip together -> reset-equivalent state;
  - assert rst mid-RUN asynchronously -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pomodoro_pkg.sv
// pomodoro_pkg
//   Shared encodings for the pomodoro sequencer and the elaboration-time
//   helper that turns a length in seconds into a packed BCD {mm,ss} value.
//   No ports; imported by pomodoro_sequencer.
package pomodoro_pkg;

   typedef enum logic [1:0] {
      PH_WORK  = 2'd0,
      PH_SHORT = 2'd1,
      PH_LONG  = 2'd2
   } phase_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_e;

   // Returns {mm_tens, mm_ones, ss_tens, ss_ones}. Inputs up to 5999 s (99:59).
   function automatic logic [15:0] sec_to_bcd(input int unsigned sec);
      int unsigned mm;
      int unsigned ss;
      mm = sec / 60;
      ss = sec % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// bcd_down_counter
//   Four-digit BCD mm:ss down-counter, digit radixes (msd..lsd) 10/10/6/10.
//   Ports:
//     clk, rst        clock, async active-high reset (loads RST_VAL)
//     load, load_val  synchronous load, wins over dec
//     dec             decrement by one second with digit borrow
//     value           current {mm,ss} BCD value
//     zero_next       value is 00:01, so the next dec reaches 00:00
module bcd_down_counter #(
   parameter logic [15:0] RST_VAL = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        dec,
   output logic [15:0] value,
   output logic        zero_next
);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;
   logic        borrow;

   always_comb begin
      cnt_d  = cnt_q;
      borrow = 1'b0;
      if (load) begin
         cnt_d = load_val;
      end else if (dec) begin
         borrow = 1'b1;
         for (int i = 0; i < 4; i++) begin
            if (borrow) begin
               if (cnt_q[4*i +: 4] == 4'd0) begin
                  // digit 1 is seconds-tens, the only radix-6 digit
                  cnt_d[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
               end else begin
                  cnt_d[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
                  borrow          = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= RST_VAL;
      else     cnt_q <= cnt_d;
   end

   assign value     = cnt_q;
   assign zero_next = (cnt_q == 16'h0001);

endmodule

// File: rtl/pomodoro_sequencer.sv
// pomodoro_sequencer
//   Work / short-break / long-break countdown sequencer with BCD display
//   outputs and a BCD completed-session counter.
//   Ports:
//     clk, rst      clock, async active-high reset
//     start_pause   pulse: IDLE->RUN, RUN<->PAUSE
//     skip          pulse: abandon phase, load next phase, go IDLE
//     clr           pulse: synchronous return to reset state
//     mm_bcd/ss_bcd BCD minutes / seconds remaining
//     phase         0=WORK 1=SHORT 2=LONG
//     running       high in RUN
//     sess_bcd      completed work sessions, 4 BCD digits
//     done          one-cycle pulse alongside the 00:00 display
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | phase time loaded, prescaler at 0, waiting for start
//   ST_RUN   | prescaler counting, one second decremented per tick
//   ST_PAUSE | counting frozen, prescaler value kept for mid-second resume
//
//   end_q marks the single cycle where 00:00 is shown; the next phase is
//   selected and loaded from it, so phase/wcnt change together with mm:ss.
module pomodoro_sequencer
   import pomodoro_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 125_000_000,
   parameter int unsigned WORK_SEC   = 1500,
   parameter int unsigned SHORT_SEC  = 300,
   parameter int unsigned LONG_SEC   = 900,
   parameter int unsigned LONG_EVERY = 4,
   parameter int unsigned AUTO_START = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_pause,
   input  logic        skip,
   input  logic        clr,
   output logic [7:0]  mm_bcd,
   output logic [7:0]  ss_bcd,
   output logic [1:0]  phase,
   output logic        running,
   output logic [15:0] sess_bcd,
   output logic        done
);

   localparam logic [15:0] WORK_BCD  = sec_to_bcd(WORK_SEC);
   localparam logic [15:0] SHORT_BCD = sec_to_bcd(SHORT_SEC);
   localparam logic [15:0] LONG_BCD  = sec_to_bcd(LONG_SEC);
   localparam int          PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRESC_TC  = PW'(CLK_HZ - 1);
   localparam logic [3:0]    WCNT_LAST = 4'(LONG_EVERY - 1);

   state_e        state_q, state_d;
   phase_e        phase_q, phase_d;
   logic [3:0]    wcnt_q, wcnt_d;
   logic [15:0]   sess_q, sess_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          done_q, done_d;
   logic          end_q, end_d;

   logic          cnt_load;
   logic          cnt_dec;
   logic [15:0]   cnt_load_val;
   logic [15:0]   cnt_val;
   logic          cnt_zero_next;
   logic          tick;
   logic [15:0]   sess_inc;
   logic          carry;

   function automatic logic [15:0] phase_time(input phase_e p);
      case (p)
         PH_SHORT: return SHORT_BCD;
         PH_LONG:  return LONG_BCD;
         default:  return WORK_BCD;
      endcase
   endfunction

   bcd_down_counter #(
      .RST_VAL (WORK_BCD)
   ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .load      (cnt_load),
      .load_val  (cnt_load_val),
      .dec       (cnt_dec),
      .value     (cnt_val),
      .zero_next (cnt_zero_next)
   );

   assign tick = (presc_q == PRESC_TC);

   // 9999 wraps to 0000 because the carry simply falls off the top digit
   always_comb begin
      sess_inc = sess_q;
      carry    = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (sess_q[4*i +: 4] == 4'd9) begin
               sess_inc[4*i +: 4] = 4'd0;
            end else begin
               sess_inc[4*i +: 4] = sess_q[4*i +: 4] + 4'd1;
               carry              = 1'b0;
            end
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      wcnt_d       = wcnt_q;
      sess_d       = sess_q;
      presc_d      = presc_q;
      done_d       = 1'b0;
      end_d        = 1'b0;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      cnt_load_val = WORK_BCD;

      if (clr) begin
         state_d  = ST_IDLE;
         phase_d  = PH_WORK;
         wcnt_d   = '0;
         sess_d   = '0;
         presc_d  = '0;
         cnt_load = 1'b1;
      end else if (skip) begin
         phase_d      = (phase_q == PH_WORK) ? PH_SHORT : PH_WORK;
         state_d      = ST_IDLE;
         presc_d      = '0;
         cnt_load     = 1'b1;
         cnt_load_val = phase_time(phase_d);
      end else if (end_q) begin
         if (phase_q == PH_WORK) begin
            if (wcnt_q == WCNT_LAST) begin
               phase_d = PH_LONG;
               wcnt_d  = '0;
            end else begin
               phase_d = PH_SHORT;
               wcnt_d  = wcnt_q + 4'd1;
            end
         end else begin
            phase_d = PH_WORK;
         end
         cnt_load     = 1'b1;
         cnt_load_val = phase_time(phase_d);
         state_d      = (AUTO_START != 0) ? ST_RUN : ST_IDLE;
      end else if (state_q == ST_RUN) begin
         if (tick && cnt_zero_next) begin
            cnt_dec = 1'b1;
            done_d  = 1'b1;
            end_d   = 1'b1;
            presc_d = '0;
            if (phase_q == PH_WORK) sess_d = sess_inc;
         end else if (start_pause) begin
            // prescaler is frozen as-is so resume continues mid-second
            state_d = ST_PAUSE;
         end else if (tick) begin
            presc_d = '0;
            cnt_dec = 1'b1;
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end else if (start_pause) begin
         state_d = ST_RUN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         phase_q <= PH_WORK;
         wcnt_q  <= '0;
         sess_q  <= '0;
         presc_q <= '0;
         done_q  <= 1'b0;
         end_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         wcnt_q  <= wcnt_d;
         sess_q  <= sess_d;
         presc_q <= presc_d;
         done_q  <= done_d;
         end_q   <= end_d;
      end
   end

   assign mm_bcd   = cnt_val[15:8];
   assign ss_bcd   = cnt_val[7:0];
   assign phase    = phase_q;
   assign running  = (state_q == ST_RUN);
   assign sess_bcd = sess_q;
   assign done     = done_q;

endmodule

// File: tb/tb_pomodoro_sequencer.sv
// tb_pomodoro_sequencer
//   Directed bench. u_dut uses the short test timing (4 Hz, 3/2/5 s,
//   long break every 2nd work). u_fast ticks every cycle with 1 s phases
//   and auto-start so the session counter can be driven up to 9999 and
//   across its wrap within a small cycle budget.
module tb_pomodoro_sequencer;

   logic        clk = 1'b0;
   logic        rst, start_pause, skip, clr;
   logic [7:0]  mm_bcd, ss_bcd;
   logic [1:0]  phase;
   logic        running, done;
   logic [15:0] sess_bcd;

   logic        rst2, sp2;
   logic [7:0]  mm2, ss2;
   logic [1:0]  phase2;
   logic        running2, done2;
   logic [15:0] sess2;

   logic [15:0] mmss;
   int          n_cmp    = 0;
   int          n_bad    = 0;
   int          done_cnt = 0;

   assign mmss = {mm_bcd, ss_bcd};

   pomodoro_sequencer #(
      .CLK_HZ(4), .WORK_SEC(3), .SHORT_SEC(2), .LONG_SEC(5),
      .LONG_EVERY(2), .AUTO_START(0)
   ) u_dut (
      .clk(clk), .rst(rst), .start_pause(start_pause), .skip(skip), .clr(clr),
      .mm_bcd(mm_bcd), .ss_bcd(ss_bcd), .phase(phase), .running(running),
      .sess_bcd(sess_bcd), .done(done)
   );

   pomodoro_sequencer #(
      .CLK_HZ(1), .WORK_SEC(1), .SHORT_SEC(1), .LONG_SEC(1),
      .LONG_EVERY(1), .AUTO_START(1)
   ) u_fast (
      .clk(clk), .rst(rst2), .start_pause(sp2), .skip(1'b0), .clr(1'b0),
      .mm_bcd(mm2), .ss_bcd(ss2), .phase(phase2), .running(running2),
      .sess_bcd(sess2), .done(done2)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input logic p_sp, input logic p_sk, input logic p_cl);
      start_pause = p_sp;
      skip        = p_sk;
      clr         = p_cl;
      @(posedge clk);
      #1;
      start_pause = 1'b0;
      skip        = 1'b0;
      clr         = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rst2 = 1'b1; sp2 = 1'b0;
      start_pause = 1'b0; skip = 1'b0; clr = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk_val("rst_mmss", mmss, 16'h0003);
      chk_val("rst_phase", phase, 2'd0);
      chk_val("rst_running", running, 1'b0);
      chk_val("rst_sess", sess_bcd, 16'h0000);
      chk_val("rst_done", done, 1'b0);
      step(20);
      chk_val("idle_mmss", mmss, 16'h0003);
      chk_val("idle_running", running, 1'b0);
      chk_val("idle_done_cnt", done_cnt, 0);

      // first WORK phase
      pulse(1, 0, 0);
      chk_val("w1_running", running, 1'b1);
      step(3);  chk_val("w1_03", mmss, 16'h0003);
      step(1);  chk_val("w1_02", mmss, 16'h0002);
      step(4);  chk_val("w1_01", mmss, 16'h0001);
      step(3);  chk_val("w1_no_early_done", done, 1'b0);
      step(1);
      chk_val("w1_00", mmss, 16'h0000);
      chk_val("w1_done", done, 1'b1);
      chk_val("w1_sess", sess_bcd, 16'h0001);
      step(1);
      chk_val("w1_done_off", done, 1'b0);
      chk_val("w1_next_phase", phase, 2'd1);
      chk_val("w1_next_mmss", mmss, 16'h0002);
      chk_val("w1_next_running", running, 1'b0);
      chk_val("w1_done_cnt", done_cnt, 1);

      // SHORT break with pause at prescaler=2 and resume
      pulse(1, 0, 0);
      step(2);
      pulse(1, 0, 0);
      chk_val("pause_running", running, 1'b0);
      step(10);
      chk_val("pause_hold", mmss, 16'h0002);
      chk_val("pause_still", running, 1'b0);
      pulse(1, 0, 0);
      chk_val("resume_running", running, 1'b1);
      step(1);  chk_val("resume_1cyc", mmss, 16'h0002);
      step(1);  chk_val("resume_tick", mmss, 16'h0001);
      step(3);  chk_val("s1_01", mmss, 16'h0001);
      step(1);
      chk_val("s1_00", mmss, 16'h0000);
      chk_val("s1_done", done, 1'b1);
      step(1);
      chk_val("s1_next_phase", phase, 2'd0);
      chk_val("s1_next_mmss", mmss, 16'h0003);
      chk_val("s1_sess", sess_bcd, 16'h0001);

      // second WORK leads to LONG
      pulse(1, 0, 0);
      step(12);
      chk_val("w2_done", done, 1'b1);
      chk_val("w2_sess", sess_bcd, 16'h0002);
      step(1);
      chk_val("w2_next_phase", phase, 2'd2);
      chk_val("w2_next_mmss", mmss, 16'h0005);
      chk_val("w2_running", running, 1'b0);

      // LONG break back to WORK
      pulse(1, 0, 0);
      step(19); chk_val("l1_01", mmss, 16'h0001);
      step(1);  chk_val("l1_done", done, 1'b1);
      step(1);
      chk_val("l1_next_phase", phase, 2'd0);
      chk_val("l1_next_mmss", mmss, 16'h0003);
      chk_val("l1_done_cnt", done_cnt, 4);

      // skip during WORK
      pulse(1, 0, 0);
      step(5);
      chk_val("skw_pre_mmss", mmss, 16'h0002);
      pulse(0, 1, 0);
      chk_val("skw_phase", phase, 2'd1);
      chk_val("skw_mmss", mmss, 16'h0002);
      chk_val("skw_running", running, 1'b0);
      chk_val("skw_sess", sess_bcd, 16'h0002);
      chk_val("skw_done_cnt", done_cnt, 4);

      // skip landing on the phase-end cycle of the SHORT break
      pulse(1, 0, 0);
      step(7);
      pulse(0, 1, 0);
      chk_val("ske_phase", phase, 2'd0);
      chk_val("ske_mmss", mmss, 16'h0003);
      chk_val("ske_done", done, 1'b0);
      chk_val("ske_running", running, 1'b0);
      step(1);
      chk_val("ske_done_cnt", done_cnt, 4);
      chk_val("ske_sess", sess_bcd, 16'h0002);

      // WORK after skips: wcnt was 0, so a SHORT follows
      pulse(1, 0, 0);
      step(13);
      chk_val("w3_phase", phase, 2'd1);
      chk_val("w3_sess", sess_bcd, 16'h0003);

      // clr together with skip
      pulse(1, 0, 0);
      step(3);
      pulse(0, 1, 1);
      chk_val("clr_phase", phase, 2'd0);
      chk_val("clr_mmss", mmss, 16'h0003);
      chk_val("clr_running", running, 1'b0);
      chk_val("clr_sess", sess_bcd, 16'h0000);
      chk_val("clr_done", done, 1'b0);
      pulse(1, 0, 0);
      step(12);
      chk_val("clr_w_sess", sess_bcd, 16'h0001);
      step(1);
      chk_val("clr_wcnt_short", phase, 2'd1);

      // async reset mid-RUN
      pulse(1, 0, 0);
      step(5);
      chk_val("arst_pre_mmss", mmss, 16'h0001);
      rst = 1'b1;
      #2;
      chk_val("arst_mmss", mmss, 16'h0003);
      chk_val("arst_phase", phase, 2'd0);
      chk_val("arst_running", running, 1'b0);
      chk_val("arst_sess", sess_bcd, 16'h0000);
      chk_val("arst_done", done, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      pulse(1, 0, 0);
      step(3);  chk_val("arst_presc_03", mmss, 16'h0003);
      step(1);  chk_val("arst_presc_02", mmss, 16'h0002);

      // session counter through 9999 and wrap on the fast instance
      rst2 = 1'b0;
      sp2  = 1'b1;
      @(posedge clk);
      #1 sp2 = 1'b0;
      for (int k = 0; k < 44000 && sess2 !== 16'h9999; k++) step(1);
      chk_val("fast_reach_9999", sess2, 16'h9999);
      for (int k = 0; k < 10 && sess2 === 16'h9999; k++) step(1);
      chk_val("fast_wrap_0000", sess2, 16'h0000);
      chk_val("fast_phase_legal", {1'b0, (phase2 == 2'd3)}, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
